screen_sequencer: RTL
=====================

Name: screen_sequencer

Overview:
Top-level screen-mode controller for the VGA game path. FSM sequences TITLE -> FADE -> PLAY -> OVER -> TITLE and selects which pixel source (title image, game scene, game-over overlay) drives the registered 8-bit RGB332 output. Mode changes happen only at frame boundaries, so there is no tearing. Also blinks a "press start" bar on the title screen and dims the title during the fade.

Parameters:
AV_Y, 480, active lines; the frame boundary is at y == AV_Y.
BLINK_FRAMES, 30, frames per on/off half-period of the press-start bar.
FADE_FRAMES, 8, frames per fade step (4 steps, 0..3).
OVER_MIN_FRAMES, 120, frames OVER must hold before start is honoured.
BAR_Y0, 400, first line of the press-start bar (bar is 8 lines, x 192..447).
TIMEOUT_FRAMES, 600, OVER auto-exit delay (optional feature only).

Ports:
clk  in  1  system/pixel clock
reset  in  1  asynchronous, active-low reset
x  in  10  current pixel column
y  in  10  current pixel row
video_on  in  1  high in the active region
start_btn  in  1  raw start button, asynchronous, active-high
game_over  in  1  level from the game module
title_color  in  8  title image pixel
game_color  in  8  game scene pixel
over_color  in  8  game-over overlay pixel (0 = transparent)
rgb  out  8  registered output pixel
mode  out  2  0=TITLE 1=FADE 2=PLAY 3=OVER
game_enable  out  1  high only in PLAY
frame_tick  out  1  one-cycle frame-boundary pulse

Behaviour:
- Reset (reset low, async): rgb=0, mode=TITLE, game_enable=0, frame_tick=0. All counters=0, pending=0, sync flops=0.
- start_btn: two-flop synchronizer, then rising-edge detect, giving start_pulse (1 cycle).
- frame_tick: registered. Pulses 1 cycle on the first clk where (x==0 && y==AV_Y) becomes true; it is edge-detected, so a multi-cycle pixel still gives one pulse.
- pending flag:
  - Set by start_pulse in TITLE.
  - Set by start_pulse in OVER only when over_cnt >= OVER_MIN_FRAMES.
  - Cleared on every state transition.
  - start_pulse in FADE or PLAY is ignored.
- FSM: transitions only on frame_tick.
  - TITLE: pending -> FADE; fade_step=0, fade_cnt=0.
  - FADE: fade_cnt counts frames. When fade_cnt reaches FADE_FRAMES-1: fade_cnt=0 and fade_step++. On a frame_tick with fade_step==3 and fade_cnt==FADE_FRAMES-1 -> PLAY. Dwell is 4*FADE_FRAMES frames.
  - PLAY: game_over sampled high at frame_tick -> OVER; over_cnt=0.
  - OVER: over_cnt increments per frame and saturates at its max. pending -> TITLE; blink_cnt=0.
- blink_cnt: counts frames in TITLE, wrapping at 2*BLINK_FRAMES. Bar is visible when blink_cnt < BLINK_FRAMES.
- Pixel select (combinational, then registered into rgb; 1-clk latency from x/y/colors):
  - video_on=0 -> 0.
  - TITLE: inside the visible bar -> 8'hFF, else title_color.
  - FADE: title_color dimmed per channel: R[7:5]>>fade_step, G[4:2]>>fade_step, B[1:0]>>fade_step. Bar not drawn.
  - PLAY: game_color.
  - OVER: over_color if nonzero, else game_color.
- game_enable = (mode==PLAY), registered with mode.
- Simultaneous events:
  - start_pulse on the same cycle as frame_tick in TITLE: pending is set that cycle; the transition waits for the next frame_tick.
  - game_over high in TITLE/FADE: ignored.
- Reset mid-frame or mid-fade: immediate return to TITLE, rgb=0.

Optional Feature:
ATTRACT_TIMEOUT_EN
- Defined: in OVER, when over_cnt reaches TIMEOUT_FRAMES with no pending, the next frame_tick forces the transition to TITLE.
- Undefined: OVER is left only via start; no timeout logic is synthesized.

Test Plan:
- Reset: hold reset=0 with random inputs -> rgb=0, mode=0, game_enable=0. Release -> rgb tracks title_color=8'h5A with 1-clk latency while video_on=1.
- Blink (BLINK_FRAMES=2): x=200, y=402 in TITLE -> rgb=FF in frames 0-1, title_color in frames 2-3, repeating.
- Start/fade (FADE_FRAMES=1): start pulse mid-frame, title_color=8'hFF:
  - mode stays 0 until the next frame_tick, then becomes 1.
  - rgb=FF, then 8'h6D (step 1), 8'h24, 8'h00 on successive frames.
  - 4th tick in FADE -> mode=2, game_enable=1.
- Game over: game_over=1 mid-frame -> mode=3 exactly at the next frame_tick. over_color=0 -> rgb=game_color; over_color=8'hE0 -> rgb=E0.
- OVER hold (OVER_MIN_FRAMES=3): start at over_cnt=1 -> ignored. Start at over_cnt=3 -> TITLE at the next frame_tick. Start during PLAY -> no effect.
- Async reset asserted mid-FADE between clock edges -> mode=0 and rgb=0 immediately. With ATTRACT_TIMEOUT_EN and TIMEOUT_FRAMES=5, idle OVER returns to TITLE after 5 frames.

Source files
------------

// File: rtl/screen_sequencer.sv
// screen_sequencer: VGA screen-mode FSM (TITLE/FADE/PLAY/OVER) and registered RGB332 pixel select.
// Optional macro ATTRACT_TIMEOUT_EN adds an automatic OVER -> TITLE exit after TIMEOUT_FRAMES.
module screen_sequencer #(
    parameter int AV_Y            = 480,
    parameter int BLINK_FRAMES    = 30,
    parameter int FADE_FRAMES     = 8,
    parameter int OVER_MIN_FRAMES = 120,
    parameter int BAR_Y0          = 400,
    parameter int TIMEOUT_FRAMES  = 600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       video_on,
    input  logic       start_btn,
    input  logic       game_over,
    input  logic [7:0] title_color,
    input  logic [7:0] game_color,
    input  logic [7:0] over_color,
    output logic [7:0] rgb,
    output logic [1:0] mode,
    output logic       game_enable,
    output logic       frame_tick
);
    typedef enum logic [1:0] {TITLE = 2'd0, FADE = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_t;
    localparam int OW = $clog2(OVER_MIN_FRAMES + TIMEOUT_FRAMES + 2);
    localparam int BW = $clog2(2 * BLINK_FRAMES + 1);
    localparam int FW = $clog2(FADE_FRAMES + 1);
    state_t          st;
    logic            s_meta, s_sync, s_prev, start_pulse;
    logic            at_bnd, bnd_prev;
    logic            pending, in_bar, bar_on, timeout;
    logic [FW-1:0]   fade_cnt;
    logic [1:0]      fade_step;
    logic [OW-1:0]   over_cnt;
    logic [BW-1:0]   blink_cnt;
    logic [7:0]      dim, pix;
    assign mode        = st;
    assign start_pulse = s_sync && !s_prev;
    assign at_bnd      = (x == 10'd0) && (y == 10'(AV_Y));
`ifdef ATTRACT_TIMEOUT_EN
    assign timeout = over_cnt >= OW'(TIMEOUT_FRAMES);
`else
    assign timeout = 1'b0;
`endif
    always_comb begin
        in_bar = (y >= 10'(BAR_Y0)) && (y < 10'(BAR_Y0 + 8)) && (x >= 10'd192) && (x <= 10'd447);
        bar_on = blink_cnt < BW'(BLINK_FRAMES);
        dim    = {title_color[7:5] >> fade_step, title_color[4:2] >> fade_step, title_color[1:0] >> fade_step};
        pix    = !video_on   ? 8'h00 :
                 st == TITLE ? ((in_bar && bar_on) ? 8'hFF : title_color) :
                 st == FADE  ? dim :
                 st == PLAY  ? game_color :
                 (over_color != 8'h00 ? over_color : game_color);
    end
    // Mode changes are gated by frame_tick so the source switch never lands mid-frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st          <= TITLE;
            rgb         <= 8'h00;
            game_enable <= 1'b0;
            frame_tick  <= 1'b0;
            s_meta      <= 1'b0;
            s_sync      <= 1'b0;
            s_prev      <= 1'b0;
            bnd_prev    <= 1'b0;
            pending     <= 1'b0;
            fade_cnt    <= '0;
            fade_step   <= 2'd0;
            over_cnt    <= '0;
            blink_cnt   <= '0;
        end else begin
            s_meta     <= start_btn;
            s_sync     <= s_meta;
            s_prev     <= s_sync;
            bnd_prev   <= at_bnd;
            frame_tick <= at_bnd && !bnd_prev;
            rgb        <= pix;
            if (start_pulse && (st == TITLE || (st == OVER && over_cnt >= OW'(OVER_MIN_FRAMES))))
                pending <= 1'b1;
            if (frame_tick) begin
                case (st)
                    TITLE: begin
                        if (pending) begin
                            st        <= FADE;
                            fade_step <= 2'd0;
                            fade_cnt  <= '0;
                            pending   <= 1'b0;
                        end else begin
                            blink_cnt <= (blink_cnt == BW'(2 * BLINK_FRAMES - 1)) ? '0 : blink_cnt + 1'b1;
                        end
                    end
                    FADE: begin
                        if (fade_cnt == FW'(FADE_FRAMES - 1)) begin
                            fade_cnt <= '0;
                            if (fade_step == 2'd3) begin
                                st          <= PLAY;
                                game_enable <= 1'b1;
                                pending     <= 1'b0;
                            end else begin
                                fade_step <= fade_step + 1'b1;
                            end
                        end else begin
                            fade_cnt <= fade_cnt + 1'b1;
                        end
                    end
                    PLAY: begin
                        if (game_over) begin
                            st          <= OVER;
                            game_enable <= 1'b0;
                            over_cnt    <= '0;
                            pending     <= 1'b0;
                        end
                    end
                    OVER: begin
                        if (over_cnt != '1)
                            over_cnt <= over_cnt + 1'b1;
                        if (pending || timeout) begin
                            st        <= TITLE;
                            blink_cnt <= '0;
                            pending   <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
